simple_dual_rw_ram_ctl: RTL and testbench



---
 rtl/simple_dual_rw_ram_ctl.sv | 133 +++++++++++++
 tb/tb_simple_dual_rw_ram_ctl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_rw_ram_ctl.sv
// Simple dual-port RAM with zero-fill sequencer; read_valid READ_LATENCY (1|2) cycles after an accepted read.
// No backpressure on reads; busy is high while clearing and upstream must hold traffic (requests are dropped).
module simple_dual_rw_ram_ctl #(
    parameter int LAYER        = 1,
    parameter int ID           = 1,
    parameter int WIDTH        = 16,
    parameter int SIZE         = 512,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0,
    parameter int INIT_CLEAR   = 1,
    localparam int AW          = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic             busy,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_en,
    input  logic [AW-1:0]    raddr,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   SIZE_W = (AW + 1)'(SIZE);
    localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;
    logic              init_pend;
    logic              clear_req, wr_acc, rd_acc;
    logic              waddr_ok, raddr_ok;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  mem [SIZE];
    logic              s1_vld;
    logic [WIDTH-1:0]  s1_dat;
    logic              unused_tag;

    assign unused_tag = ^{32'(LAYER), 32'(ID)};

    assign waddr_ok = {1'b0, waddr} < SIZE_W;
    assign raddr_ok = {1'b0, raddr} < SIZE_W;
    assign busy     = (state == CLEAR);

    // A pending clear (requested or post-reset) wins over a same-cycle write.
    always_comb begin
        clear_req = (state == IDLE) && (clear || init_pend);
        wr_acc    = (state == IDLE) && write_en && !clear_req && waddr_ok;
        rd_acc    = (state == IDLE) && read_en;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            init_pend <= (INIT_CLEAR != 0);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            mem[waddr] <= write_data;
        end
    end

    always_comb begin
        rd_word = '0;
        if (!raddr_ok) begin
            rd_word = '0;
        end else if ((WRITE_FIRST != 0) && wr_acc && (waddr == raddr)) begin
            rd_word = write_data;
        end else begin
            rd_word = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) s1_dat <= rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic             s2_vld;
        logic [WIDTH-1:0] s2_dat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) s2_dat <= s1_dat;
            end
        end

        assign read_valid = s2_vld;
        assign read_data  = s2_dat;
    end else begin : g_lat1
        assign read_valid = s1_vld;
        assign read_data  = s1_dat;
    end

endmodule

// File: tb/tb_simple_dual_rw_ram_ctl.sv
// Two instances (SIZE 8 / latency 1 / write-first, SIZE 6 / latency 2 / read-first) share one stimulus
// stream; a behavioural model queues expected read results with their due cycle.
`timescale 1ns/1ps
module tb_simple_dual_rw_ram_ctl;

    logic        clk = 1'b0;
    logic        rst_n, clear, write_en, read_en;
    logic [2:0]  waddr, raddr;
    logic [15:0] write_data;
    logic        busy_a, busy_b, rv_a, rv_b;
    logic [15:0] rd_a, rd_b;

    always #5 clk = ~clk;

    simple_dual_rw_ram_ctl #(.WIDTH(16), .SIZE(8), .READ_LATENCY(1), .WRITE_FIRST(1), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_a),
        .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .read_data(rd_a), .read_valid(rv_a)
    );

    simple_dual_rw_ram_ctl #(.WIDTH(16), .SIZE(6), .READ_LATENCY(2), .WRITE_FIRST(0), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_b),
        .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .read_data(rd_b), .read_valid(rv_b)
    );

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    exp_t        q [2][$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          na, nb;
    int          sz  [2] = '{8, 6};
    int          lat [2] = '{1, 2};
    int          wf  [2] = '{1, 0};
    logic [15:0] mm  [2][8];
    logic        m_busy [2];
    int          m_cnt  [2];
    logic        m_init [2];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_cnt[d]  = 0;
            m_init[d] = 1'b1;
            q[d].delete();
        end
    endtask

    task automatic step(logic c, logic we, logic [2:0] wa, logic [15:0] wd, logic re, logic [2:0] ra);
        exp_t e;
        logic wacc [2];
        clear = c; write_en = we; waddr = wa; write_data = wd; read_en = re; raddr = ra;
        for (int d = 0; d < 2; d++) begin
            wacc[d] = 1'b0;
            if (rst_n) begin
                wacc[d] = !m_busy[d] && we && !(c || m_init[d]) && (int'(wa) < sz[d]);
                if (!m_busy[d] && re) begin
                    if (int'(ra) >= sz[d])                          e.d = 16'h0;
                    else if (wf[d] == 1 && wacc[d] && wa == ra)     e.d = wd;
                    else                                            e.d = mm[d][ra];
                    e.due = cyc + lat[d];
                    q[d].push_back(e);
                end
            end
        end
        @(posedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (m_busy[d]) begin
                    mm[d][m_cnt[d]] = 16'h0;
                    if (m_cnt[d] == sz[d] - 1) begin
                        m_busy[d] = 1'b0;
                        m_cnt[d]  = 0;
                    end else begin
                        m_cnt[d]++;
                    end
                end else if (c || m_init[d]) begin
                    m_busy[d] = 1'b1;
                end else if (wacc[d]) begin
                    mm[d][wa] = wd;
                end
                m_init[d] = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    endtask

    // First step carries the given request; reads keep coming for rd_cycles steps.
    task automatic run_clear(logic c, logic we, logic [2:0] a, logic [15:0] wd, int rd_cycles);
        na = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            step(c && i == 0, we && i == 0, a, wd, i < rd_cycles, a);
            na += int'(busy_a);
            nb += int'(busy_b);
            if (!m_busy[0] && !m_busy[1]) break;
        end
        chk("clear_len_a", na, 8);
        chk("clear_len_b", nb, 6);
    endtask

    task automatic mon(int d, logic v, logic [15:0] dat, logic b);
        exp_t e;
        chk($sformatf("busy%0d", d), b, m_busy[d]);
        if (v) begin
            if (q[d].size() == 0) begin
                chk($sformatf("spurious_valid%0d", d), v, 0);
            end else begin
                e = q[d].pop_front();
                chk($sformatf("data%0d", d), dat, e.d);
                chk($sformatf("due%0d", d), cyc, e.due);
            end
        end else if (q[d].size() > 0 && q[d][0].due <= cyc) begin
            chk($sformatf("missing_valid%0d", d), v, 1);
            void'(q[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv_a, rd_a, busy_a);
        mon(1, rv_b, rd_b, busy_b);
    end

    initial begin
        model_reset();
        rst_n = 1'b0; clear = 1'b0; write_en = 1'b0; read_en = 1'b0;
        waddr = '0; raddr = '0; write_data = '0;
        #1;
        chk("rst_rd_a", rd_a, 0);   chk("rst_rv_a", rv_a, 0);   chk("rst_busy_a", busy_a, 0);
        chk("rst_rd_b", rd_b, 0);   chk("rst_rv_b", rv_b, 0);   chk("rst_busy_b", busy_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_clear(1'b0, 1'b0, 3'd0, 16'h0, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));
        idle(3);

        step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7);
        idle(3);

        step(1'b0, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
        idle(3);

        step(1'b0, 1'b1, 3'd2, 16'h4321, 1'b0, 3'd0);
        run_clear(1'b1, 1'b1, 3'd2, 16'h00FF, 5);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
        idle(3);

        step(1'b0, 1'b1, 3'd6, 16'h7777, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));
        idle(3);

        for (int i = 0; i < 150; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        idle(3);

        step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
        idle(3);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        idle(3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_rd_a", rd_a, 0);  chk("arst_rv_a", rv_a, 0);  chk("arst_busy_a", busy_a, 0);
        chk("arst_rd_b", rd_b, 0);  chk("arst_rv_b", rv_b, 0);  chk("arst_busy_b", busy_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(1'b0, 1'b0, 3'd0, 16'h0, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));
        idle(4);

        chk("drain_a", q[0].size(), 0);
        chk("drain_b", q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
